svo_video_timing: RTL and testbench

- Raster timing generator and pixel-stream framer that sits directly upstream of the three per-channel TMDS encoders.
- Consumes a valid/ready RGB pixel stream tagged with start-of-frame.
- Produces registered `de`, the 2-bit control word (`{vsync, hsync}`) and 8-bit R/G/B for the encoders.
- Recovers frame alignment when the stream and the raster disagree.

---
 rtl/svo_video_timing.sv | 175 +++++++++++++++++
 tb/tb_svo_video_timing.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/svo_video_timing.sv
`default_nettype none
// ============================================================================
// Module   : svo_video_timing
// Brief    : Raster timing generator and pixel-stream framer feeding the
//            three TMDS channel encoders (de, {vsync,hsync}, R/G/B).
// Revision : 1.0 - initial release
// ============================================================================
module svo_video_timing #(
    parameter int          H_ACTIVE = 800,
    parameter int          H_FP     = 40,
    parameter int          H_SYNC   = 128,
    parameter int          H_BP     = 88,
    parameter int          V_ACTIVE = 600,
    parameter int          V_FP     = 1,
    parameter int          V_SYNC   = 4,
    parameter int          V_BP     = 23,
    parameter logic        HS_POL   = 1'b1,
    parameter logic        VS_POL   = 1'b1,
    parameter logic [23:0] FILL_RGB = 24'h000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] in_rgb,
    input  logic        in_sof,
    input  logic        clr_flags,
    output logic        out_de,
    output logic [1:0]  out_ctrl,
    output logic [7:0]  out_r,
    output logic [7:0]  out_g,
    output logic [7:0]  out_b,
    output logic        frame_start,
    output logic        underflow,
    output logic        resync
);

    localparam int c_h_total  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_v_total  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_hw       = $clog2(c_h_total);
    localparam int c_vw       = $clog2(c_v_total);
    localparam int c_hs_start = H_ACTIVE + H_FP;
    localparam int c_hs_end   = c_hs_start + H_SYNC;
    localparam int c_vs_start = V_ACTIVE + V_FP;
    localparam int c_vs_end   = c_vs_start + V_SYNC;
    localparam logic [c_hw-1:0] c_h_last = c_hw'(c_h_total - 1);
    localparam logic [c_vw-1:0] c_v_last = c_vw'(c_v_total - 1);

    typedef enum logic [0:0] {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [c_hw-1:0]   h_cnt_q, h_cnt_d;
    logic [c_vw-1:0]   v_cnt_q, v_cnt_d;
    logic              de_q, de_d;
    logic [1:0]        ctrl_q, ctrl_d;
    logic [23:0]       rgb_q, rgb_d;
    logic              fs_q, fs_d;
    logic              uf_q, uf_d;
    logic              rs_q, rs_d;

    logic              w_active;
    logic              w_first_px;
    logic              w_hs_on;
    logic              w_vs_on;
    logic              w_accept;
    logic              w_show;
    logic              w_set_uf;
    logic              w_set_rs;

    // Raster position and region decode
    always_comb begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == c_h_last) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == c_v_last) ? '0 : v_cnt_q + 1'b1;
        end
    end

    assign w_active   = (int'(h_cnt_q) < H_ACTIVE) && (int'(v_cnt_q) < V_ACTIVE);
    assign w_first_px = (h_cnt_q == '0) && (v_cnt_q == '0);
    assign w_hs_on    = (int'(h_cnt_q) >= c_hs_start) && (int'(h_cnt_q) < c_hs_end);
    assign w_vs_on    = (int'(v_cnt_q) >= c_vs_start) && (int'(v_cnt_q) < c_vs_end);

    // Stream alignment FSM; w_show marks an accepted beat that lands on screen
    always_comb begin
        state_d  = state_q;
        w_accept = 1'b0;
        w_show   = 1'b0;
        w_set_uf = 1'b0;
        w_set_rs = 1'b0;
        case (state_q)
            SEARCH: begin
                if (in_valid && !in_sof) begin
                    w_accept = 1'b1;
                end else if (in_valid && in_sof && w_active && w_first_px) begin
                    w_accept = 1'b1;
                    w_show   = 1'b1;
                    state_d  = LOCKED;
                end
            end
            LOCKED: begin
                if (w_active) begin
                    // SOF must coincide exactly with pixel (0,0); either mismatch drops lock
                    if (in_valid && (in_sof != w_first_px)) begin
                        w_set_rs = 1'b1;
                        state_d  = SEARCH;
                    end else if (in_valid) begin
                        w_accept = 1'b1;
                        w_show   = 1'b1;
                    end else begin
                        w_set_uf = 1'b1;
                    end
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    assign in_ready = w_accept && !reset;

    always_comb begin
        de_d   = w_active;
        ctrl_d = {w_vs_on ? VS_POL : ~VS_POL, w_hs_on ? HS_POL : ~HS_POL};
        fs_d   = w_active && w_first_px;
        if (!w_active) begin
            rgb_d = 24'h000000;
        end else if (w_show) begin
            rgb_d = in_rgb;
        end else begin
            rgb_d = FILL_RGB;
        end
        // A set event outranks a simultaneous clear
        uf_d = w_set_uf || (uf_q && !clr_flags);
        rs_d = w_set_rs || (rs_q && !clr_flags);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SEARCH;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            de_q    <= 1'b0;
            ctrl_q  <= {~VS_POL, ~HS_POL};
            rgb_q   <= 24'h000000;
            fs_q    <= 1'b0;
            uf_q    <= 1'b0;
            rs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            de_q    <= de_d;
            ctrl_q  <= ctrl_d;
            rgb_q   <= rgb_d;
            fs_q    <= fs_d;
            uf_q    <= uf_d;
            rs_q    <= rs_d;
        end
    end

    assign out_de      = de_q;
    assign out_ctrl    = ctrl_q;
    assign out_r       = rgb_q[23:16];
    assign out_g       = rgb_q[15:8];
    assign out_b       = rgb_q[7:0];
    assign frame_start = fs_q;
    assign underflow   = uf_q;
    assign resync      = rs_q;

endmodule
`default_nettype wire

// File: tb/tb_svo_video_timing.sv
`default_nettype none
// ============================================================================
// Module   : tb_svo_video_timing
// Brief    : Directed self-checking bench for svo_video_timing on an 8x6 raster.
// Revision : 1.0 - initial release
// ============================================================================
module tb_svo_video_timing;

    localparam logic [23:0] FILL    = 24'hFF00FF;
    localparam logic [29:0] RST_VEC = 30'h0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] in_rgb = 24'h0;
    logic        in_sof = 1'b0;
    logic        clr_flags = 1'b0;
    logic        out_de;
    logic [1:0]  out_ctrl;
    logic [7:0]  out_r, out_g, out_b;
    logic        frame_start, underflow, resync;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    svo_video_timing #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .FILL_RGB(24'hFF00FF)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_rgb(in_rgb), .in_sof(in_sof),
        .clr_flags(clr_flags),
        .out_de(out_de), .out_ctrl(out_ctrl),
        .out_r(out_r), .out_g(out_g), .out_b(out_b),
        .frame_start(frame_start), .underflow(underflow), .resync(resync)
    );

    // Raster index idx counts clocks from (0,0); 48 clocks per frame
    function automatic logic is_act(int idx);
        int pos = idx % 48;
        return ((pos % 8) < 4) && ((pos / 8) < 3);
    endfunction

    function automatic int pix(int idx);
        int pos = idx % 48;
        return (pos / 8) * 4 + (pos % 8);
    endfunction

    // Number of active pixels of this frame already passed (12 = frame done)
    function automatic int pend(int idx);
        int pos = idx % 48;
        int h = pos % 8;
        int v = pos / 8;
        if (v >= 3) return 12;
        if (h < 4) return v * 4 + h;
        return (v + 1) * 4;
    endfunction

    function automatic logic [23:0] beat(int f, int p);
        return {8'(8'hC0 + f), 8'(p), 8'h5A};
    endfunction

    function automatic logic [29:0] exp_vec(int idx, logic [23:0] rgb, logic uf, logic rs);
        int pos = idx % 48;
        int h = pos % 8;
        int v = pos / 8;
        logic de, vs, hs, fs;
        de = (h < 4) && (v < 3);
        vs = (v == 4);
        hs = (h == 5) || (h == 6);
        fs = (pos == 0);
        return {de, vs, hs, fs, de ? rgb : 24'h0, uf, rs};
    endfunction

    function automatic logic [29:0] obs();
        return {out_de, out_ctrl, frame_start, out_r, out_g, out_b, underflow, resync};
    endfunction

    task automatic drive(input logic v, input logic s, input logic [23:0] d, input logic c);
        in_valid  = v;
        in_sof    = s;
        in_rgb    = d;
        clr_flags = c;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 1'b1, 24'h123456, 1'b1);
        #23;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got=%b exp=0", in_ready);
        end
        checks++;
        if (obs() !== RST_VEC) begin
            errors++;
            $display("FAIL reset_out got=%h exp=%h", obs(), RST_VEC);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic test_free_run();
        logic [29:0] ev;
        while (cyc < 46) begin
            drive(1'b0, 1'b0, 24'h0, 1'b0);
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL free_ready idx=%0d got=%b exp=0", cyc, in_ready);
            end
            step();
            ev = exp_vec(cyc - 1, FILL, 1'b0, 1'b0);
            checks++;
            if (obs() !== ev) begin
                errors++;
                $display("FAIL free_out idx=%0d got=%h exp=%h", cyc - 1, obs(), ev);
            end
        end
    endtask

    task automatic test_aligned();
        logic [29:0] ev;
        int f, pd;
        logic er;
        while (cyc < 96) begin
            f  = cyc / 48;
            pd = pend(cyc);
            if (pd == 12) drive(1'b1, 1'b1, beat(f + 1, 0), 1'b0);
            else          drive(1'b1, pd == 0, beat(f, pd), 1'b0);
            er = is_act(cyc);
            #1;
            checks++;
            if (in_ready !== er) begin
                errors++;
                $display("FAIL aligned_ready idx=%0d got=%b exp=%b", cyc, in_ready, er);
            end
            step();
            ev = exp_vec(cyc - 1, beat(f, pix(cyc - 1)), 1'b0, 1'b0);
            checks++;
            if (obs() !== ev) begin
                errors++;
                $display("FAIL aligned_out idx=%0d got=%h exp=%h", cyc - 1, obs(), ev);
            end
        end
    endtask

    // Pixel (2,1) starves; the late stream's last beat is abandoned so frame 3 starts clean
    task automatic test_gap();
        logic [29:0] ev;
        logic [23:0] erg;
        int pos, pd, p;
        logic er;
        while (cyc < 144) begin
            pos = cyc % 48;
            if (pos == 10) begin
                drive(1'b0, 1'b0, 24'h0, 1'b0);
            end else begin
                pd = pend(cyc);
                if (pos > 10 && pd < 12) pd--;
                if (pd == 12) drive(1'b1, 1'b1, beat(3, 0), 1'b0);
                else          drive(1'b1, pd == 0, beat(2, pd), 1'b0);
            end
            er = is_act(cyc) && (pos != 10);
            #1;
            checks++;
            if (in_ready !== er) begin
                errors++;
                $display("FAIL gap_ready idx=%0d got=%b exp=%b", cyc, in_ready, er);
            end
            step();
            p = pix(cyc - 1);
            if (pos == 10)     erg = FILL;
            else if (pos > 10) erg = beat(2, p - 1);
            else               erg = beat(2, p);
            ev = exp_vec(cyc - 1, erg, pos >= 10, 1'b0);
            checks++;
            if (obs() !== ev) begin
                errors++;
                $display("FAIL gap_out idx=%0d got=%h exp=%h", cyc - 1, obs(), ev);
            end
        end
    endtask

    task automatic test_early_sof();
        logic [29:0] ev;
        int pos, pd;
        logic er;
        while (cyc < 192) begin
            pos = cyc % 48;
            if (pos < 9) begin
                pd = pend(cyc);
                drive(1'b1, pd == 0, beat(3, pd), 1'b0);
                er = is_act(cyc);
            end else begin
                drive(1'b1, 1'b1, beat(4, 0), 1'b0);
                er = 1'b0;
            end
            #1;
            checks++;
            if (in_ready !== er) begin
                errors++;
                $display("FAIL early_sof_ready idx=%0d got=%b exp=%b", cyc, in_ready, er);
            end
            step();
            ev = exp_vec(cyc - 1, (pos < 9) ? beat(3, pix(cyc - 1)) : FILL, 1'b1, pos >= 9);
            checks++;
            if (obs() !== ev) begin
                errors++;
                $display("FAIL early_sof_out idx=%0d got=%h exp=%h", cyc - 1, obs(), ev);
            end
        end
    endtask

    // Frame 4 relocks, clears the flags, then parks a stray non-SOF beat for frame 5
    task automatic test_clear_flags();
        logic [29:0] ev;
        int pos, pd;
        logic er, clr;
        while (cyc < 240) begin
            pos = cyc % 48;
            pd  = pend(cyc);
            clr = (pos == 20);
            if (pd == 12) drive(1'b1, 1'b0, beat(5, 1), clr);
            else          drive(1'b1, pd == 0, beat(4, pd), clr);
            er = is_act(cyc);
            #1;
            checks++;
            if (in_ready !== er) begin
                errors++;
                $display("FAIL clear_ready idx=%0d got=%b exp=%b", cyc, in_ready, er);
            end
            step();
            ev = exp_vec(cyc - 1, beat(4, pix(cyc - 1)), pos < 20, pos < 20);
            checks++;
            if (obs() !== ev) begin
                errors++;
                $display("FAIL clear_out idx=%0d got=%h exp=%h", cyc - 1, obs(), ev);
            end
        end
    endtask

    task automatic test_nonsof_at_origin();
        logic [29:0] ev;
        int pos;
        logic er;
        while (cyc < 288) begin
            pos = cyc % 48;
            if (pos == 0) begin
                drive(1'b1, 1'b0, beat(5, 1), 1'b0);
                er = 1'b0;
            end else if (pos <= 5) begin
                drive(1'b1, 1'b0, beat(5, pos + 1), 1'b0);
                er = 1'b1;
            end else begin
                drive(1'b1, 1'b1, beat(6, 0), 1'b0);
                er = 1'b0;
            end
            #1;
            checks++;
            if (in_ready !== er) begin
                errors++;
                $display("FAIL nonsof_ready idx=%0d got=%b exp=%b", cyc, in_ready, er);
            end
            step();
            ev = exp_vec(cyc - 1, FILL, 1'b0, 1'b1);
            checks++;
            if (obs() !== ev) begin
                errors++;
                $display("FAIL nonsof_out idx=%0d got=%h exp=%h", cyc - 1, obs(), ev);
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [29:0] ev;
        int pd;
        logic er;
        while (cyc < 298) begin
            pd = pend(cyc);
            drive(1'b1, pd == 0, beat(6, pd), 1'b0);
            er = is_act(cyc);
            #1;
            checks++;
            if (in_ready !== er) begin
                errors++;
                $display("FAIL midframe_ready idx=%0d got=%b exp=%b", cyc, in_ready, er);
            end
            step();
            ev = exp_vec(cyc - 1, beat(6, pix(cyc - 1)), 1'b0, 1'b1);
            checks++;
            if (obs() !== ev) begin
                errors++;
                $display("FAIL midframe_out idx=%0d got=%h exp=%h", cyc - 1, obs(), ev);
            end
        end
        drive(1'b1, 1'b0, beat(6, 6), 1'b0);
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (obs() !== RST_VEC) begin
            errors++;
            $display("FAIL async_reset_out got=%h exp=%h", obs(), RST_VEC);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_ready got=%b exp=0", in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (obs() !== RST_VEC) begin
            errors++;
            $display("FAIL held_reset_out got=%h exp=%h", obs(), RST_VEC);
        end
        reset = 1'b0;
        cyc   = 0;
    endtask

    // Draining at idx 0 shows SEARCH at (0,0); idx 49 raises underflow under clr_flags
    task automatic test_flag_priority();
        logic [29:0] ev;
        logic [23:0] erg;
        logic er, euf;
        while (cyc < 51) begin
            euf = 1'b0;
            erg = FILL;
            if (cyc == 0) begin
                drive(1'b1, 1'b0, beat(7, 1), 1'b0);
                er = 1'b1;
            end else if (cyc < 48) begin
                drive(1'b1, 1'b1, beat(7, 0), 1'b0);
                er = 1'b0;
            end else if (cyc == 48) begin
                drive(1'b1, 1'b1, beat(7, 0), 1'b0);
                er  = 1'b1;
                erg = beat(7, 0);
            end else if (cyc == 49) begin
                drive(1'b0, 1'b0, 24'h0, 1'b1);
                er  = 1'b0;
                euf = 1'b1;
            end else begin
                drive(1'b1, 1'b0, beat(7, 1), 1'b1);
                er  = 1'b1;
                erg = beat(7, 1);
            end
            #1;
            checks++;
            if (in_ready !== er) begin
                errors++;
                $display("FAIL priority_ready idx=%0d got=%b exp=%b", cyc, in_ready, er);
            end
            step();
            ev = exp_vec(cyc - 1, erg, euf, 1'b0);
            checks++;
            if (obs() !== ev) begin
                errors++;
                $display("FAIL priority_out idx=%0d got=%h exp=%h", cyc - 1, obs(), ev);
            end
        end
        drive(1'b0, 1'b0, 24'h0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_aligned();
        test_gap();
        test_early_sof();
        test_clear_flags();
        test_nonsof_at_origin();
        test_reset_midframe();
        test_flag_priority();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
